async_fifo_wr_arb: RTL and testbench

Round-robin write-port arbiter that lets N_REQ producers in the write clock domain share the single write port of async_fifo.
- Grants one requester at a time.
- The granted requester may push a burst of up to MAX_BURST beats, with a valid/ready handshake per beat.
- Drives the FIFO w_en_i/w_data_i from the winner and honours w_full_o back-pressure.
- Sits between the producers and async_fifo, clocked by the FIFO write clock.

---
 rtl/async_fifo_wr_arb.sv | 145 ++++++++++++++
 tb/tb_async_fifo_wr_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_arb.sv
// ============================================================================
// Module   : async_fifo_wr_arb
// Brief    : Round-robin burst arbiter sharing one async_fifo write port among
//            N_REQ producers. Define ASYNC_FIFO_WR_ARB_STATS_EN for stall_cnt_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module async_fifo_wr_arb #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]            req_last_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic                        w_en_o,
  output logic [DATA_WIDTH-1:0]       w_data_o,
  input  logic                        w_full_i,
  output logic [ID_W-1:0]             grant_id_o,
  output logic                        busy_o
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]                 stall_cnt_o
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state_q,    state_d;
  logic [ID_W-1:0]  rr_ptr_q,   rr_ptr_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [DATA_WIDTH-1:0] w_data_arr [N_REQ];
  logic                  w_found;
  logic [ID_W-1:0]       w_winner;
  logic [ID_W-1:0]       w_idx;
  logic                  w_in_grant;
  logic                  w_gvalid;
  logic                  w_glast;
  logic                  w_xfer;
  logic                  w_release;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign w_data_arr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester scanning upward from rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
      if (!w_found && req_valid_i[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_in_grant = (state_q == ST_GRANT);
  assign w_gvalid   = req_valid_i[grant_id_q];
  assign w_glast    = req_last_i[grant_id_q];
  assign w_xfer     = w_in_grant & w_gvalid & ~w_full_i;
  assign w_release  = w_in_grant &
                      (~w_gvalid |
                       (w_xfer & (w_glast | (beat_cnt_q == CNT_W'(MAX_BURST - 1)))));

  always_comb begin
    req_ready_o = '0;
    if (w_in_grant) begin
      req_ready_o[grant_id_q] = ~w_full_i;
    end
  end

  assign w_en_o     = w_xfer;
  assign w_data_o   = w_in_grant ? w_data_arr[grant_id_q] : '0;
  assign grant_id_o = grant_id_q;
  assign busy_o     = w_in_grant;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          grant_id_d = w_winner;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      default: begin
        if (w_xfer) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        if (w_release) begin
          rr_ptr_d = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
          state_d  = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (w_in_grant && w_gvalid && w_full_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_async_fifo_wr_arb.sv
// ============================================================================
// Module   : tb_async_fifo_wr_arb
// Brief    : Directed self-checking bench for async_fifo_wr_arb (4 req, 8b, burst 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_async_fifo_wr_arb;

  localparam int N_REQ      = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;
  localparam int ID_W       = 2;

  logic                        clk;
  logic                        rst_n;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_last;
  logic [N_REQ-1:0]            req_ready;
  logic                        w_en;
  logic [DATA_WIDTH-1:0]       w_data;
  logic                        w_full;
  logic [ID_W-1:0]             grant_id;
  logic                        busy;
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
  logic [15:0]                 stall_cnt;
`endif

  int n_vec;
  int n_err;

  async_fifo_wr_arb #(
    .N_REQ      (N_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .w_en_o      (w_en),
    .w_data_o    (w_data),
    .w_full_i    (w_full),
    .grant_id_o  (grant_id),
    .busy_o      (busy)
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_data(input int k, input logic [7:0] val);
    req_data[k*DATA_WIDTH +: DATA_WIDTH] = val;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    chk({tag, ".w_en"},  32'(w_en),      32'd0);
    chk({tag, ".busy"},  32'(busy),      32'd0);
    chk({tag, ".ready"}, 32'(req_ready), 32'd0);
    next_cycle();
  endtask

  task automatic expect_write(input string tag, input int gid, input logic [7:0] data);
    @(negedge clk);
    chk({tag, ".w_en"},  32'(w_en),      32'd1);
    chk({tag, ".data"},  32'(w_data),    32'(data));
    chk({tag, ".gid"},   32'(grant_id),  32'(gid));
    chk({tag, ".ready"}, 32'(req_ready), 32'd1 << gid);
    chk({tag, ".busy"},  32'(busy),      32'd1);
    next_cycle();
  endtask

  task automatic expect_stall(input string tag, input int gid);
    @(negedge clk);
    chk({tag, ".w_en"},  32'(w_en),      32'd0);
    chk({tag, ".ready"}, 32'(req_ready), 32'd0);
    chk({tag, ".busy"},  32'(busy),      32'd1);
    chk({tag, ".gid"},   32'(grant_id),  32'(gid));
    next_cycle();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    w_full    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int ord [5];
    n_vec = 0;
    n_err = 0;

    // T1: reset with all requesters valid
    rst_n     = 1'b0;
    req_last  = '0;
    w_full    = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < N_REQ; k++) set_data(k, 8'(8'h10 + k));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1.rst.w_en",  32'(w_en),      32'd0);
    chk("t1.rst.ready", 32'(req_ready), 32'd0);
    chk("t1.rst.busy",  32'(busy),      32'd0);
    chk("t1.rst.gid",   32'(grant_id),  32'd0);
    chk("t1.rst.data",  32'(w_data),    32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_idle("t1.c0");
    expect_write("t1.c1", 0, 8'h10);
    req_valid = '0;
    @(negedge clk);
    chk("t1.abandon.w_en", 32'(w_en), 32'd0);
    next_cycle();

    // T2: single requester, burst cap then new grant after a bubble
    do_reset();
    req_valid = 4'b0100;
    set_data(2, 8'hA0);
    expect_idle("t2.c0");
    for (int b = 0; b < 4; b++) begin
      set_data(2, 8'(8'hA0 + b));
      expect_write("t2.burst", 2, 8'(8'hA0 + b));
    end
    set_data(2, 8'hA4);
    @(negedge clk);
    chk("t2.bubble.w_en", 32'(w_en),     32'd0);
    chk("t2.bubble.busy", 32'(busy),     32'd0);
    chk("t2.bubble.gid",  32'(grant_id), 32'd2);
    next_cycle();
    expect_write("t2.regrant", 2, 8'hA4);
    req_valid = '0;
    next_cycle();

    // T3: all valid, rotation 0,1,2,3,0
    do_reset();
    req_valid = 4'hF;
    for (int k = 0; k < N_REQ; k++) set_data(k, 8'(8'h30 + k));
    ord = '{0, 1, 2, 3, 0};
    expect_idle("t3.c0");
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < MAX_BURST; b++) begin
        expect_write("t3.rr", ord[g], 8'(8'h30 + ord[g]));
      end
      if (g < 4) expect_idle("t3.gap");
    end

    // T4: back-pressure stall mid-burst
    do_reset();
    req_valid = 4'b0010;
    set_data(1, 8'h40);
    expect_idle("t4.c0");
    expect_write("t4.b1", 1, 8'h40);
    set_data(1, 8'h41);
    expect_write("t4.b2", 1, 8'h41);
    set_data(1, 8'h42);
    w_full = 1'b1;
    for (int s = 0; s < 3; s++) expect_stall("t4.stall", 1);
    w_full = 1'b0;
    expect_write("t4.b3", 1, 8'h42);
    set_data(1, 8'h43);
    expect_write("t4.b4", 1, 8'h43);
    req_valid = '0;
    expect_idle("t4.after");
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
    chk("t4.stall_cnt", 32'(stall_cnt), 32'd3);
`endif

    // T5: 1-beat burst from req 3 then wrap to req 0
    do_reset();
    req_valid = 4'b0100;
    req_last  = 4'b0100;
    set_data(2, 8'h52);
    expect_idle("t5.c0");
    expect_write("t5.r2", 2, 8'h52);
    req_valid = 4'b1001;
    req_last  = 4'b1000;
    set_data(3, 8'h53);
    set_data(0, 8'h50);
    expect_idle("t5.c2");
    expect_write("t5.r3", 3, 8'h53);
    expect_idle("t5.c4");
    expect_write("t5.r0", 0, 8'h50);
    req_valid = '0;
    req_last  = '0;
    next_cycle();

    // T6: abandoned burst hands over to req 1
    do_reset();
    req_valid = 4'b0011;
    set_data(0, 8'h60);
    set_data(1, 8'h61);
    expect_idle("t6.c0");
    expect_write("t6.r0", 0, 8'h60);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("t6.drop.w_en", 32'(w_en), 32'd0);
    next_cycle();
    expect_idle("t6.c3");
    expect_write("t6.r1", 1, 8'h61);
    req_valid = '0;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
